// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bus of the PISO serializer: parallel handshake side plus serial stream side.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, sout, sout_valid, frame_start, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, sout, sout_valid, frame_start, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word hold buffer so back-to-back words stream gap-free.
// state | meaning
// IDLE  | no frame in progress, sout held low
// SHIFT | one bit of the current word on sout per cycle
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               rst,
    piso_serializer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, hold;
    logic             hold_full;
    logic [CW-1:0]    cnt;
    logic             xfer, last_bit;
    logic             load_din, load_hold, hold_wr, shift_en;

    assign xfer     = bus.din_valid && !hold_full;
    assign last_bit = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_din  = 1'b0;
        load_hold = 1'b0;
        hold_wr   = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    load_din  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    // a queued word wins over a word arriving on this very edge
                    if (hold_full)  load_hold = 1'b1;
                    else if (xfer)  load_din  = 1'b1;
                    else            state_nxt = IDLE;
                end else begin
                    shift_en = 1'b1;
                    hold_wr  = xfer;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr        <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else begin
            if (load_hold)     sr <= hold;
            else if (load_din) sr <= bus.din;
            else if (shift_en) begin
                if (MSB_FIRST != 0) sr <= {sr[WIDTH-2:0], 1'b0};
                else                sr <= {1'b0, sr[WIDTH-1:1]};
            end

            if (last_bit || load_din) cnt <= '0;
            else if (shift_en)        cnt <= cnt + CW'(1);

            if (hold_wr) hold <= bus.din;

            if (load_hold)    hold_full <= 1'b0;
            else if (hold_wr) hold_full <= 1'b1;
        end
    end

    assign bus.din_ready   = !hold_full;
    assign bus.sout_valid  = (state == SHIFT);
    assign bus.frame_start = (state == SHIFT) && (cnt == '0);
    assign bus.busy        = (state == SHIFT) || hold_full;
    assign bus.sout        = (state == SHIFT) &&
                             ((MSB_FIRST != 0) ? sr[WIDTH-1] : sr[0]);
endmodule
